// File: rtl/seq_add_sub.sv
// Digit-serial adder/subtractor: operands latched on start, CHUNK bits per clock LSB first.
// Optional ADDSUB_SAT_EN clamps the result to signed max/min on overflow.
module seq_add_sub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = $clog2(N + 1);

  generate
    if ((WIDTH < 2) || (CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_param_check
      $error("seq_add_sub: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_op;
  logic             r_carry;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_zero;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic [CW-1:0]    w_idx;
  logic [CHUNK-1:0] w_slice;
  logic [CHUNK:0]   w_chain;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_final;
  logic             w_ovf;

  assign w_accept = start && (r_state != S_RUN);
  assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(1));
  assign w_idx    = CW'(N) - r_cnt;

  // One slice of ripple arithmetic; carry/borrow enters from the register.
  assign w_chain[0] = r_carry;
  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_slice
      assign w_slice[gi]     = r_a[gi] ^ r_b[gi] ^ w_chain[gi];
      assign w_chain[gi + 1] = r_op
        ? ((r_a[gi] & r_b[gi]) | (w_chain[gi] & (r_a[gi] ^ r_b[gi])))
        : ((~r_a[gi] & (r_b[gi] ^ w_chain[gi])) | (r_b[gi] & w_chain[gi]));
    end
  endgenerate

  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[int'(w_idx) * CHUNK +: CHUNK] = w_slice;
  end

  assign w_ovf = r_op
    ? ((r_a_msb == r_b_msb) && (w_acc_next[WIDTH-1] != r_a_msb))
    : ((r_a_msb != r_b_msb) && (w_acc_next[WIDTH-1] != r_a_msb));

`ifdef ADDSUB_SAT_EN
  // A negative A can only overflow downward, a non-negative A only upward.
  assign w_final = !w_ovf ? w_acc_next
                 : (r_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
`else
  assign w_final = w_acc_next;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_op     <= 1'b0;
      r_carry  <= 1'b0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_acc   <= '0;
        r_op    <= op;
        r_carry <= cin;
        r_a_msb <= a[WIDTH-1];
        r_b_msb <= b[WIDTH-1];
        r_cnt   <= CW'(N);
      end else if (r_state == S_RUN) begin
        r_a     <= r_a >> CHUNK;
        r_b     <= r_b >> CHUNK;
        r_acc   <= w_acc_next;
        r_carry <= w_chain[CHUNK];
        r_cnt   <= r_cnt - CW'(1);
        if (w_last) begin
          r_result <= w_final;
          r_cout   <= w_chain[CHUNK];
          r_zero   <= (w_final == '0);
          r_ovf    <= w_ovf;
        end
      end
    end
  end

  assign busy   = (r_state == S_RUN);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign cout   = r_cout;
  assign zero   = r_zero;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_seq_add_sub.sv
// Scoreboard bench for seq_add_sub (WIDTH=8, CHUNK=2); honours ADDSUB_SAT_EN in its model.
module tb_seq_add_sub;
  localparam int W = 8;
  localparam int C = 2;
  localparam int N = W / C;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, zero, ovf;
  logic [W-1:0] result;

  int total = 0;
  int bad   = 0;
  logic [W+2:0] exp_q[$];

  seq_add_sub #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .cin(cin), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: {result, cout, zero, ovf} from full-width integer arithmetic.
  function automatic logic [W+2:0] model(input logic iop, input logic icin,
                                         input logic [W-1:0] ia, input logic [W-1:0] ib);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         v;
    if (iop) full = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, icin};
    else     full = {1'b0, ia} - {1'b0, ib} - {{W{1'b0}}, icin};
    r = full[W-1:0];
    if (iop) v = (ia[W-1] == ib[W-1]) && (r[W-1] != ia[W-1]);
    else     v = (ia[W-1] != ib[W-1]) && (r[W-1] != ia[W-1]);
`ifdef ADDSUB_SAT_EN
    if (v) r = ia[W-1] ? 8'h80 : 8'h7F;
`endif
    return {r, full[W], (r == '0), v};
  endfunction

  // Start is high for exactly one clock; returns at the falling edge of cycle 1.
  task automatic issue(input logic iop, input logic icin, input logic [W-1:0] ia, input logic [W-1:0] ib);
    @(negedge clk);
    start = 1'b1; op = iop; cin = icin; a = ia; b = ib;
    exp_q.push_back(model(iop, icin, ia, ib));
    $display("issue op=%0d cin=%0d a=%h b=%h", iop, icin, ia, ib);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, result, cout, zero, ovf} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h expected=0", {busy, done, result, cout, zero, ovf});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add_overflow;
    int cyc;
    int busy_n;
    logic [W+2:0] exp;
    issue(1'b1, 1'b0, 8'h7F, 8'h01);
    cyc = 1; busy_n = 0;
    while (!done && cyc < 20) begin
      if (busy) busy_n++;
      @(negedge clk);
      cyc++;
    end
    total++;
    if (cyc !== N + 1) begin bad++; $display("FAIL add_ovf_latency got=%0d expected=%0d", cyc, N + 1); end
    total++;
    if (busy_n !== N) begin bad++; $display("FAIL add_ovf_busy_cycles got=%0d expected=%0d", busy_n, N); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL add_ovf_busy_at_done got=%b expected=0", busy); end
    exp = exp_q.pop_front();
    total++;
    if ({result, cout, zero, ovf} !== exp) begin
      bad++; $display("FAIL add_ovf_value got=%h expected=%h", {result, cout, zero, ovf}, exp);
    end
    $display("done result=%h cout=%b zero=%b ovf=%b", result, cout, zero, ovf);
  endtask

  task automatic test_sub_borrow;
    int cyc;
    logic [W+2:0] exp;
    issue(1'b0, 1'b0, 8'h05, 8'h07);
    wait_done(cyc);
    exp = exp_q.pop_front();
    total++;
    if (cyc !== N + 1) begin bad++; $display("FAIL sub_borrow_latency got=%0d expected=%0d", cyc, N + 1); end
    total++;
    if ({result, cout, zero, ovf} !== exp) begin
      bad++; $display("FAIL sub_borrow_value got=%h expected=%h", {result, cout, zero, ovf}, exp);
    end
    $display("done result=%h cout=%b zero=%b ovf=%b", result, cout, zero, ovf);
  endtask

  task automatic test_add_carry;
    int cyc;
    logic [W+2:0] exp;
    for (int k = 0; k < 2; k++) begin
      issue(1'b1, k[0], 8'hFF, 8'h01);
      wait_done(cyc);
      exp = exp_q.pop_front();
      total++;
      if ({result, cout, zero, ovf} !== exp) begin
        bad++; $display("FAIL add_carry_cin%0d got=%h expected=%h", k, {result, cout, zero, ovf}, exp);
      end
      $display("done result=%h cout=%b zero=%b ovf=%b", result, cout, zero, ovf);
    end
  endtask

  task automatic test_ignored_start;
    int ndone;
    int first;
    logic [W+2:0] exp;
    issue(1'b0, 1'b0, 8'h80, 8'h01);
    @(negedge clk);                       // cycle 2
    start = 1'b1; a = 8'h11; b = 8'h22; op = 1'b1;
    @(negedge clk);                       // cycle 3
    start = 1'b0;
    ndone = 0; first = 0;
    exp = exp_q.pop_front();
    for (int cyc = 3; cyc < 15; cyc++) begin
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          first = cyc;
          total++;
          if ({result, cout, zero, ovf} !== exp) begin
            bad++; $display("FAIL ignored_start_value got=%h expected=%h", {result, cout, zero, ovf}, exp);
          end
          $display("done result=%h cout=%b zero=%b ovf=%b", result, cout, zero, ovf);
        end
      end
      @(negedge clk);
    end
    total++;
    if (ndone !== 1) begin bad++; $display("FAIL ignored_start_done_count got=%0d expected=1", ndone); end
    total++;
    if (first !== N + 1) begin bad++; $display("FAIL ignored_start_done_cycle got=%0d expected=%0d", first, N + 1); end
  endtask

  task automatic test_reset_mid_run;
    int ndone;
    issue(1'b1, 1'b0, 8'h12, 8'h34);
    @(negedge clk);                       // cycle 2
    @(negedge clk);                       // cycle 3
    rst_n = 1'b0;
    @(negedge clk);                       // cycle 4
    exp_q.delete();
    total++;
    if ({busy, done, result, cout, zero, ovf} !== '0) begin
      bad++; $display("FAIL reset_mid_run_outputs got=%h expected=0", {busy, done, result, cout, zero, ovf});
    end
    rst_n = 1'b1;
    ndone = 0;
    repeat (10) begin
      if (done) ndone++;
      @(negedge clk);
    end
    total++;
    if (ndone !== 0) begin bad++; $display("FAIL reset_mid_run_done_count got=%0d expected=0", ndone); end
    $display("reset mid-run: aborted, done pulses=%0d", ndone);
  endtask

  task automatic test_back_to_back;
    int dc[$];
    logic [W+2:0] exp;
    @(negedge clk);
    start = 1'b1; op = 1'b1; cin = 1'b1; a = 8'h3C; b = 8'h55;
    exp_q.push_back(model(1'b1, 1'b1, 8'h3C, 8'h55));
    @(negedge clk);                       // cycle 1: present second operand set
    op = 1'b0; cin = 1'b1; a = 8'h10; b = 8'h20;
    exp_q.push_back(model(1'b0, 1'b1, 8'h10, 8'h20));
    for (int cyc = 1; cyc <= 13; cyc++) begin
      if (cyc == 6) start = 1'b0;
      if (done) begin
        dc.push_back(cyc);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        total++;
        if ({result, cout, zero, ovf} !== exp) begin
          bad++; $display("FAIL back_to_back_value got=%h expected=%h", {result, cout, zero, ovf}, exp);
        end
        $display("done cycle=%0d result=%h cout=%b zero=%b ovf=%b", cyc, result, cout, zero, ovf);
      end
      @(negedge clk);
    end
    total++;
    if (dc.size() !== 2) begin
      bad++; $display("FAIL back_to_back_done_count got=%0d expected=2", dc.size());
    end else begin
      total++;
      if (dc[0] !== N + 1 || dc[1] !== 2 * (N + 1)) begin
        bad++; $display("FAIL back_to_back_done_cycles got=%0d,%0d expected=%0d,%0d", dc[0], dc[1], N + 1, 2 * (N + 1));
      end
    end
  endtask

  task automatic test_random;
    int cyc;
    logic [W+2:0] exp;
    for (int k = 0; k < 12; k++) begin
      issue(1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom_range(255)), 8'($urandom_range(255)));
      wait_done(cyc);
      exp = exp_q.pop_front();
      total++;
      if (cyc !== N + 1 || {result, cout, zero, ovf} !== exp) begin
        bad++; $display("FAIL random_%0d got=%h@%0d expected=%h@%0d", k, {result, cout, zero, ovf}, cyc, exp, N + 1);
      end
      $display("done result=%h cout=%b zero=%b ovf=%b", result, cout, zero, ovf);
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_borrow();
    test_add_carry();
    test_ignored_start();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
